pattern_sequencer: RTL and testbench

//   Game-round controller that drives the pattern/score datapath. On start it runs NUM_ROUNDS rounds.

---
 rtl/pattern_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pattern_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: game-round controller for the pattern/score datapath.
// On start it plays NUM_ROUNDS rounds. Each round is a blank gap of
// GAP_TICKS ticks followed by a pseudo-random target held HOLD_TICKS ticks.
//
// Optional feature macro: PATTERN_SEQ_HIT_ADVANCE_EN
//   defined   : a tick in SHOW with user_input == pattern ends the round early
//   undefined : user_input is ignored, every SHOW lasts HOLD_TICKS ticks
//
// Ports:
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   tick       in   1  1-clk timing pulse; all durations count these
//   start      in   1  1-clk pulse, begins a game (IDLE/DONE only)
//   abort      in   1  1-clk pulse, returns to IDLE from any state
//   user_input in   8  player switch vector
//   pattern    out  8  current target, 8'h00 when nothing is shown
//   round      out  5  index of the current/last round
//   busy       out  1  high while in GAP or SHOW
//   done       out  1  high in DONE until the next start/abort

module pattern_sequencer #(
    parameter int          NUM_ROUNDS = 16,
    parameter int          HOLD_TICKS = 20,
    parameter int          GAP_TICKS  = 5,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] user_input,
    output logic [7:0] pattern,
    output logic [4:0] round,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_t;

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [7:0] SEED =
        (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    localparam logic [7:0] GAP_LAST   = 8'(GAP_TICKS - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);
    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] pattern_q;
    logic [7:0] pattern_d;
    logic [4:0] round_q;
    logic [4:0] round_d;
    logic [7:0] tick_cnt_q;
    logic [7:0] tick_cnt_d;
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    logic [7:0] lfsr_next;
    logic       hit;
    logic       gap_end;
    logic       show_end;

    assign lfsr_next = {lfsr_q[6:0],
                        lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

`ifdef PATTERN_SEQ_HIT_ADVANCE_EN
    // Compared against the registered target, i.e. what the player sees.
    assign hit = (user_input == pattern_q);
`else
    logic unused_user_input;
    assign unused_user_input = ^user_input;
    assign hit = 1'b0;
`endif

    assign gap_end  = (tick_cnt_q == GAP_LAST);
    assign show_end = (tick_cnt_q == HOLD_LAST) || hit;

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        round_d    = round_q;
        tick_cnt_d = tick_cnt_q;
        lfsr_d     = lfsr_q;

        if (abort) begin
            state_d    = IDLE;
            pattern_d  = 8'h00;
            round_d    = 5'd0;
            tick_cnt_d = 8'd0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d    = GAP;
                        pattern_d  = 8'h00;
                        round_d    = 5'd0;
                        tick_cnt_d = 8'd0;
                        lfsr_d     = SEED;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_end) begin
                            state_d    = SHOW;
                            pattern_d  = lfsr_q;
                            lfsr_d     = lfsr_next;
                            tick_cnt_d = 8'd0;
                        end else begin
                            tick_cnt_d = tick_cnt_q + 8'd1;
                        end
                    end
                end
                SHOW: begin
                    if (tick) begin
                        if (show_end) begin
                            pattern_d  = 8'h00;
                            tick_cnt_d = 8'd0;
                            if (round_q == LAST_ROUND) begin
                                state_d = DONE;
                            end else begin
                                state_d = GAP;
                                round_d = round_q + 5'd1;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pattern_q  <= 8'h00;
            round_q    <= 5'd0;
            tick_cnt_q <= 8'd0;
            lfsr_q     <= SEED;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            round_q    <= round_d;
            tick_cnt_q <= tick_cnt_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign pattern = pattern_q;
    assign round   = round_q;
    assign busy    = (state_q == GAP) || (state_q == SHOW);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Testbench for pattern_sequencer: directed games with a scoreboard of
// expected output changes, each tagged with the tick count it must occur at.

module tb_pattern_sequencer;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       start;
    logic       abort;
    logic [7:0] user_input;
    logic [7:0] pattern;
    logic [4:0] round;
    logic       busy;
    logic       done;

    pattern_sequencer #(
        .NUM_ROUNDS (3),
        .HOLD_TICKS (4),
        .GAP_TICKS  (2),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start      (start),
        .abort      (abort),
        .user_input (user_input),
        .pattern    (pattern),
        .round      (round),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p;
        logic [4:0] r;
        logic       b;
        logic       d;
        int         tk;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ntick   = 0;
    logic mon_en  = 1'b0;
    logic [15:0] prev_snap;

    task automatic push(input logic [7:0] p, input logic [4:0] r,
                        input logic b, input logic d, input int tk);
        exp_t e;
        e.p = p; e.r = r; e.b = b; e.d = d; e.tk = tk;
        q.push_back(e);
    endtask

    // Monitor: any change of the output tuple must match the queue head.
    always @(posedge clk) begin
        logic [15:0] cur;
        exp_t e;
        #1;
        if (mon_en) begin
            cur = {pattern, round, busy, done, 1'b0};
            if (cur != prev_snap) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got p=%h r=%0d b=%b d=%b at tick %0d, required no change",
                             pattern, round, busy, done, ntick);
                end else begin
                    e = q.pop_front();
                    if (pattern !== e.p || round !== e.r || busy !== e.b ||
                        done !== e.d || ntick != e.tk) begin
                        n_fail++;
                        $display("FAIL change: got p=%h r=%0d b=%b d=%b tick=%0d, required p=%h r=%0d b=%b d=%b tick=%0d",
                                 pattern, round, busy, done, ntick,
                                 e.p, e.r, e.b, e.d, e.tk);
                    end
                end
                prev_snap = cur;
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            ntick++;
            @(negedge clk);
            tick = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic pulse(input logic s, input logic a);
        @(negedge clk);
        start = s;
        abort = a;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic push_game(input int t0);
        push(8'h00, 5'd0, 1'b1, 1'b0, t0);
        push(8'hA5, 5'd0, 1'b1, 1'b0, t0 + 2);
        push(8'h00, 5'd1, 1'b1, 1'b0, t0 + 6);
        push(8'h4A, 5'd1, 1'b1, 1'b0, t0 + 8);
        push(8'h00, 5'd2, 1'b1, 1'b0, t0 + 12);
        push(8'h95, 5'd2, 1'b1, 1'b0, t0 + 14);
        push(8'h00, 5'd2, 1'b0, 1'b1, t0 + 18);
    endtask

    task automatic check_now(input string name, input logic [7:0] p,
                             input logic [4:0] r, input logic b,
                             input logic d);
        n_tests++;
        if (pattern !== p || round !== r || busy !== b || done !== d) begin
            n_fail++;
            $display("FAIL %s: got p=%h r=%0d b=%b d=%b, required p=%h r=%0d b=%b d=%b",
                     name, pattern, round, busy, done, p, r, b, d);
        end
    endtask

    int t0;

    initial begin
        rst_n      = 1'b0;
        tick       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        user_input = 8'h00;
        repeat (3) @(negedge clk);
        check_now("reset_state", 8'h00, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        prev_snap = {8'h00, 5'd0, 1'b0, 1'b0, 1'b0};
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Full game with no input.
        t0 = ntick;
        push_game(t0);
        pulse(1'b1, 1'b0);
        tick_n(20);

        // start+abort together in DONE: abort wins.
        push(8'h00, 5'd0, 1'b0, 1'b0, ntick);
        pulse(1'b1, 1'b1);

        // start+abort together in IDLE: nothing changes.
        pulse(1'b1, 1'b1);
        repeat (4) @(negedge clk);

        // Abort in 2nd SHOW, with an ignored start inside SHOW first.
        t0 = ntick;
        push(8'h00, 5'd0, 1'b1, 1'b0, t0);
        push(8'hA5, 5'd0, 1'b1, 1'b0, t0 + 2);
        push(8'h00, 5'd1, 1'b1, 1'b0, t0 + 6);
        push(8'h4A, 5'd1, 1'b1, 1'b0, t0 + 8);
        pulse(1'b1, 1'b0);
        tick_n(9);
        pulse(1'b1, 1'b0);
        tick_n(1);
        push(8'h00, 5'd0, 1'b0, 1'b0, ntick);
        pulse(1'b0, 1'b1);

        // Restart replays A5, then async reset mid-SHOW.
        t0 = ntick;
        push(8'h00, 5'd0, 1'b1, 1'b0, t0);
        push(8'hA5, 5'd0, 1'b1, 1'b0, t0 + 2);
        pulse(1'b1, 1'b0);
        tick_n(3);
        push(8'h00, 5'd0, 1'b0, 1'b0, ntick);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_now("async_reset", 8'h00, 5'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Player matches A5 from the 2nd SHOW tick of round 0.
        t0 = ntick;
        push(8'h00, 5'd0, 1'b1, 1'b0, t0);
        push(8'hA5, 5'd0, 1'b1, 1'b0, t0 + 2);
`ifdef PATTERN_SEQ_HIT_ADVANCE_EN
        push(8'h00, 5'd1, 1'b1, 1'b0, t0 + 4);
        push(8'h4A, 5'd1, 1'b1, 1'b0, t0 + 6);
        push(8'h00, 5'd2, 1'b1, 1'b0, t0 + 10);
        push(8'h95, 5'd2, 1'b1, 1'b0, t0 + 12);
        push(8'h00, 5'd2, 1'b0, 1'b1, t0 + 16);
`else
        push(8'h00, 5'd1, 1'b1, 1'b0, t0 + 6);
        push(8'h4A, 5'd1, 1'b1, 1'b0, t0 + 8);
        push(8'h00, 5'd2, 1'b1, 1'b0, t0 + 12);
        push(8'h95, 5'd2, 1'b1, 1'b0, t0 + 14);
        push(8'h00, 5'd2, 1'b0, 1'b1, t0 + 18);
`endif
        pulse(1'b1, 1'b0);
        tick_n(3);
        user_input = 8'hA5;
        tick_n(17);
        user_input = 8'h00;

        // New game straight from DONE.
        t0 = ntick;
        push_game(t0);
        pulse(1'b1, 1'b0);
        tick_n(19);

        repeat (4) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_changes: got %0d outstanding, required 0",
                     q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
